result_buffer_arbiter: RTL

Shares one single-port result RAM between three result producers and a host read port. Writers 0–2 arbitrate round-robin for the RAM write port; each writer owns a circular region of DEPTH bytes. The host drains each region through a small Avalon-style slave interface with pop, occupancy and status registers. The host takes priority over writers for the RAM. The block sits between the per-channel result generators and the host bus.

---
 rtl/result_buffer_arbiter_if.sv | 37 +++
 rtl/result_buffer_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/result_buffer_arbiter_if.sv
// result_buffer_arbiter_if
// Groups the signals of result_buffer_arbiter that cross the block boundary.
//   writer side : req, wdata0..2 in; gnt, full out
//   RAM side    : ram_addr, ram_we, ram_wdata out; ram_rdata in (registered RAM)
//   host side   : chipselect, read, address in; readdata, waitrequest out
// slave modport is the block itself; master is everything around it.
interface result_buffer_arbiter_if #(
    parameter int AW = 10
);
    logic [2:0]    req;
    logic [7:0]    wdata0;
    logic [7:0]    wdata1;
    logic [7:0]    wdata2;
    logic [2:0]    gnt;
    logic [2:0]    full;

    logic [AW+1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    logic          chipselect;
    logic          read;
    logic [2:0]    address;
    logic [7:0]    readdata;
    logic          waitrequest;

    modport slave (
        input  req, wdata0, wdata1, wdata2, ram_rdata, chipselect, read, address,
        output gnt, full, ram_addr, ram_we, ram_wdata, readdata, waitrequest
    );

    modport master (
        output req, wdata0, wdata1, wdata2, ram_rdata, chipselect, read, address,
        input  gnt, full, ram_addr, ram_we, ram_wdata, readdata, waitrequest
    );
endinterface

// File: rtl/result_buffer_arbiter.sv
// result_buffer_arbiter
// Shares one single-port result RAM between three writers and a host read port.
// Each writer owns a circular region of DEPTH bytes at ram_addr = {chan, ptr}.
// Writers arbitrate round-robin; a host pop that needs the RAM takes priority.
// Ports:
//   clk     : system clock, posedge
//   reset_n : asynchronous active-low reset
//   bus     : writer / RAM / host signals (result_buffer_arbiter_if.slave)
// Host registers: 0..2 pop chan, 3 status {2'b0,full,empty},
//                 4..6 count (saturated to 255), 7 constant 8'hFC.
module result_buffer_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    result_buffer_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t       state;
    logic [AW-1:0] wr_ptr [3];
    logic [AW-1:0] rd_ptr [3];
    logic [AW:0]   count  [3];
    logic [1:0]    last_gnt;
    logic [1:0]    pop_ch;
    logic          pop_pend;   // current host transaction is a real pop
    logic [7:0]    readdata_q;

    logic [2:0]    empty;
    logic [2:0]    full_w;
    logic          host_req;
    logic          is_pop;
    logic [1:0]    sel;
    logic          pop_issue;
    logic          pop_done;
    logic [2:0]    elig;
    logic [1:0]    rr_start;
    logic [2:0]    cand;
    logic          any;
    logic [1:0]    win;
    logic [2:0]    gnt;
    logic [7:0]    reg_val;

    function automatic logic [7:0] sat8(input logic [AW:0] v);
        if (32'(v) > 32'd255) return 8'hFF;
        return 8'(v);
    endfunction

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            empty[c]  = (count[c] == '0);
            full_w[c] = (count[c] == FULL_CNT);
        end
    end

    assign host_req  = bus.chipselect & bus.read;
    assign is_pop    = (bus.address <= 3'd2);
    assign sel       = bus.address[1:0];
    // Only a pop of a non-empty channel needs the RAM; empty pops are
    // answered from the register path.
    assign pop_issue = (state == IDLE) && host_req && is_pop && !empty[sel];
    assign pop_done  = (state == RESP) && pop_pend;

    // Round-robin search starting one past the last winner. Arbitration is
    // only blocked in the single cycle the pop address owns the RAM.
    always_comb begin
        elig     = pop_issue ? 3'b000 : (bus.req & ~full_w);
        rr_start = (last_gnt == 2'd2) ? 2'd0 : last_gnt + 2'd1;
        cand     = 3'd0;
        any      = 1'b0;
        win      = 2'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, rr_start} + 3'(i);
            if (cand > 3'd2) cand = cand - 3'd3;
            if (!any && elig[cand[1:0]]) begin
                any = 1'b1;
                win = cand[1:0];
            end
        end
        gnt = any ? (3'b001 << win) : 3'b000;
    end

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = 8'h00;
        if (pop_issue) begin
            bus.ram_addr = {sel, rd_ptr[sel]};
        end else if (any) begin
            bus.ram_we   = 1'b1;
            bus.ram_addr = {win, wr_ptr[win]};
            case (win)
                2'd0:    bus.ram_wdata = bus.wdata0;
                2'd1:    bus.ram_wdata = bus.wdata1;
                default: bus.ram_wdata = bus.wdata2;
            endcase
        end
    end

    // Non-RAM read values; pop addresses only land here when the channel
    // is empty.
    always_comb begin
        case (bus.address)
            3'd3:    reg_val = {2'b00, full_w, empty};
            3'd4:    reg_val = sat8(count[0]);
            3'd5:    reg_val = sat8(count[1]);
            3'd6:    reg_val = sat8(count[2]);
            3'd7:    reg_val = 8'hFC;
            default: reg_val = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            readdata_q <= 8'h00;
            pop_ch     <= 2'd0;
            pop_pend   <= 1'b0;
            last_gnt   <= 2'd2;
            for (int c = 0; c < 3; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            if (any) begin
                last_gnt     <= win;
                wr_ptr[win]  <= wr_ptr[win] + 1'b1;
            end
            if (pop_done)
                rd_ptr[pop_ch] <= rd_ptr[pop_ch] + 1'b1;
            // Simultaneous write and pop completion cancel out.
            for (int c = 0; c < 3; c++) begin
                case ({gnt[c], pop_done && (pop_ch == 2'(c))})
                    2'b10:   count[c] <= count[c] + 1'b1;
                    2'b01:   count[c] <= count[c] - 1'b1;
                    default: count[c] <= count[c];
                endcase
            end

            case (state)
                IDLE: begin
                    if (host_req) begin
                        if (pop_issue) begin
                            pop_ch   <= sel;
                            pop_pend <= 1'b1;
                            state    <= CAPTURE;
                        end else begin
                            readdata_q <= reg_val;
                            pop_pend   <= 1'b0;
                            state      <= RESP;
                        end
                    end
                end
                CAPTURE: begin
                    readdata_q <= bus.ram_rdata;
                    state      <= RESP;
                end
                default: begin
                    pop_pend <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt;
    assign bus.full        = full_w;
    assign bus.readdata    = readdata_q;
    assign bus.waitrequest = host_req && (state != RESP);
endmodule
